// File: rtl/recip_scale_pipe.sv
// ---------------------------------------------------------------------------
// recip_scale_pipe
//
// Purpose:
//   Pipelined divide-by-small-integer unit for average pooling and
//   normalisation. LANES signed accumulator sums share one divisor index.
//   Each sum is multiplied by a reciprocal floor(2^FRAC_BITS/(idx+1)) taken
//   from a table built at elaboration. The product is then floored or rounded
//   half-up and saturated to OUT_WIDTH bits.
//
// Pipeline:
//   S1 reciprocal lookup  -> S2 exact multiply -> S3 scale/round/saturate.
//   A single global enable (en = !out_valid | out_ready) advances every stage
//   together. Bubbles are not collapsed while the pipeline is stalled.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid & in_ready (equals en)
//   in_idx     divisor index, divisor = in_idx + 1
//   in_rnd     0 = floor, 1 = round-half-up (toward +inf)
//   in_sum     LANES signed sums, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  output beat valid
//   out_ready  downstream accept
//   out_data   LANES signed results, lane k at [k*OUT_WIDTH +: OUT_WIDTH]
//   out_sat    per-lane saturation flag, aligned with out_data
// ---------------------------------------------------------------------------
module recip_scale_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 8,
    parameter int CNT_WIDTH  = 6,
    parameter int FRAC_BITS  = 13,
    parameter int LANES      = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [CNT_WIDTH-1:0]            in_idx,
    input  logic                            in_rnd,
    input  logic [LANES*DATA_WIDTH-1:0]     in_sum,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LANES*OUT_WIDTH-1:0]      out_data,
    output logic [LANES-1:0]                out_sat
);

    // Reciprocal width (unsigned) and exact product width (signed).
    localparam int RW    = FRAC_BITS + 1;
    localparam int PW    = DATA_WIDTH + FRAC_BITS + 2;
    localparam int DEPTH = 2 ** CNT_WIDTH;

    // Output range and rounding bias, expressed at product width so the
    // comparisons happen before any truncation.
    localparam logic signed [PW-1:0] OUT_MAX = PW'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [PW-1:0] OUT_MIN = PW'(-(2 ** (OUT_WIDTH - 1)));
    localparam logic signed [PW-1:0] HALF    = PW'(2 ** (FRAC_BITS - 1));

    // -----------------------------------------------------------------------
    // Arithmetic helpers
    // -----------------------------------------------------------------------

    // Signed sum times unsigned reciprocal: the reciprocal is zero-extended
    // into a signed operand so the product stays exact at PW bits.
    function automatic logic signed [PW-1:0] mul_lane(
        input logic signed [DATA_WIDTH-1:0] s,
        input logic        [RW-1:0]         r
    );
        logic signed [PW-1:0] s_ext;
        logic signed [PW-1:0] r_ext;
        s_ext = PW'(s);
        r_ext = PW'(r);
        return s_ext * r_ext;
    endfunction

    // Drop the fraction. The arithmetic shift floors; adding half first
    // gives round-half-up, which treats negative values the same way.
    function automatic logic signed [PW-1:0] scale_shift(
        input logic signed [PW-1:0] p,
        input logic                 rnd
    );
        logic signed [PW-1:0] biased;
        biased = rnd ? (p + HALF) : p;
        return biased >>> FRAC_BITS;
    endfunction

    // Clamp to OUT_WIDTH signed. Returns {sat_flag, value}.
    function automatic logic [OUT_WIDTH:0] sat_out(
        input logic signed [PW-1:0] q
    );
        logic [OUT_WIDTH:0] res;
        if (q > OUT_MAX) begin
            res = {1'b1, OUT_WIDTH'(OUT_MAX)};
        end else if (q < OUT_MIN) begin
            res = {1'b1, OUT_WIDTH'(OUT_MIN)};
        end else begin
            res = {1'b0, OUT_WIDTH'(q)};
        end
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // Reciprocal table, fixed at elaboration: recip[i] = floor(2^F/(i+1))
    // -----------------------------------------------------------------------
    logic [RW-1:0] recip_tbl [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_recip
        assign recip_tbl[gi] = RW'((2 ** FRAC_BITS) / (gi + 1));
    end

    // -----------------------------------------------------------------------
    // Pipeline state
    // -----------------------------------------------------------------------
    logic                         en;

    logic                         vld_p1_q, vld_p1_d;
    logic                         rnd_p1_q, rnd_p1_d;
    logic [RW-1:0]                recip_p1_q, recip_p1_d;
    logic signed [DATA_WIDTH-1:0] sum_p1_q [LANES];
    logic signed [DATA_WIDTH-1:0] sum_p1_d [LANES];

    logic                         vld_p2_q, vld_p2_d;
    logic                         rnd_p2_q, rnd_p2_d;
    logic signed [PW-1:0]         prod_p2_q [LANES];
    logic signed [PW-1:0]         prod_p2_d [LANES];

    logic                         out_valid_q, out_valid_d;
    logic [LANES*OUT_WIDTH-1:0]   out_data_q, out_data_d;
    logic [LANES-1:0]             out_sat_q, out_sat_d;

    // One enable for the whole pipe: advance unless a held output is waiting.
    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    always_comb begin
        // Default: every stage holds.
        vld_p1_d    = vld_p1_q;
        rnd_p1_d    = rnd_p1_q;
        recip_p1_d  = recip_p1_q;
        vld_p2_d    = vld_p2_q;
        rnd_p2_d    = rnd_p2_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        for (int k = 0; k < LANES; k++) begin
            sum_p1_d[k]  = sum_p1_q[k];
            prod_p2_d[k] = prod_p2_q[k];
        end

        if (en) begin
            vld_p1_d    = in_valid;
            vld_p2_d    = vld_p1_q;
            out_valid_d = vld_p2_q;

            // ---- S1: reciprocal lookup (data loads only on a real beat) ----
            if (in_valid) begin
                rnd_p1_d   = in_rnd;
                recip_p1_d = recip_tbl[in_idx];
                for (int k = 0; k < LANES; k++) begin
                    sum_p1_d[k] = $signed(in_sum[k*DATA_WIDTH +: DATA_WIDTH]);
                end
            end

            // ---- S2: exact signed x unsigned multiply ----
            if (vld_p1_q) begin
                rnd_p2_d = rnd_p1_q;
                for (int k = 0; k < LANES; k++) begin
                    prod_p2_d[k] = mul_lane(sum_p1_q[k], recip_p1_q);
                end
            end

            // ---- S3: scale, round, saturate ----
            if (vld_p2_q) begin
                for (int k = 0; k < LANES; k++) begin
                    {out_sat_d[k], out_data_d[k*OUT_WIDTH +: OUT_WIDTH]} =
                        sat_out(scale_shift(prod_p2_q[k], rnd_p2_q));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q    <= 1'b0;
            rnd_p1_q    <= 1'b0;
            recip_p1_q  <= '0;
            vld_p2_q    <= 1'b0;
            rnd_p2_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= '0;
            for (int k = 0; k < LANES; k++) begin
                sum_p1_q[k]  <= '0;
                prod_p2_q[k] <= '0;
            end
        end else begin
            vld_p1_q    <= vld_p1_d;
            rnd_p1_q    <= rnd_p1_d;
            recip_p1_q  <= recip_p1_d;
            vld_p2_q    <= vld_p2_d;
            rnd_p2_q    <= rnd_p2_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            for (int k = 0; k < LANES; k++) begin
                sum_p1_q[k]  <= sum_p1_d[k];
                prod_p2_q[k] <= prod_p2_d[k];
            end
        end
    end

endmodule
